// File: rtl/pwm_ctrl_pkg.sv
// Shared types and widths for the PWM duty fade controller.
package pwm_ctrl_pkg;

    localparam int DUTY_W = 8;
    localparam int STEP_W = 4;
    localparam int DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: counts 0..TICK_DIV-1 while run is high, tick on the last count.
module tick_prescaler #(
    parameter int TICK_DIV = 1000,
    parameter int TICK_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : r_cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_controller.sv
// Ramps the PWM duty toward the SPI target in programmable steps, or passes it
// straight through (one cycle late) when fading is disabled.
module pwm_fade_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int TICK_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              fade_en,
    input  logic [STEP_W-1:0] step_size,
    input  logic [DIV_W-1:0]  step_div,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_busy;
    logic [DIV_W-1:0]  r_step_cnt;
    logic [DIV_W-1:0]  w_div_last;
    logic [DUTY_W-1:0] w_step;
    logic [DUTY_W:0]   w_diff_up;
    logic [DUTY_W:0]   w_diff_dn;
    logic              w_up;
    logic              w_dn;
    logic              w_tick;
    logic              w_fire;
    logic              w_clear;
    logic              w_run;

    assign w_step     = (step_size == '0) ? DUTY_W'(1) : DUTY_W'(step_size);
    assign w_div_last = (step_div == '0) ? '0 : step_div - DIV_W'(1);
    assign w_up       = target_duty > r_duty;
    assign w_dn       = target_duty < r_duty;
    assign w_diff_up  = {1'b0, target_duty} - {1'b0, r_duty};
    assign w_diff_dn  = {1'b0, r_duty} - {1'b0, target_duty};

    // Counters sit at zero whenever idle or bypassed, so every ramp starts fresh.
    assign w_clear = !fade_en || (r_state == IDLE);
    assign w_run   = (r_state != IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // >= rather than == so shrinking step_div mid-ramp never forces a counter wrap.
    assign w_fire = w_tick && (r_step_cnt >= w_div_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
        end else if (w_clear || w_fire) begin
            r_step_cnt <= '0;
        end else if (w_tick) begin
            r_step_cnt <= r_step_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_done_nxt  = 1'b0;
        if (!fade_en) begin
            w_state_nxt = IDLE;
            w_duty_nxt  = target_duty;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_up)      w_state_nxt = UP;
                    else if (w_dn) w_state_nxt = DOWN;
                end
                UP, DOWN: begin
                    if (!w_up && !w_dn) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_fire && w_up) begin
                        if (w_diff_up <= {1'b0, w_step}) begin
                            w_duty_nxt  = target_duty;
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_duty_nxt  = r_duty + w_step;
                            w_state_nxt = UP;
                        end
                    end else if (w_fire) begin
                        if (w_diff_dn <= {1'b0, w_step}) begin
                            w_duty_nxt  = target_duty;
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_duty_nxt  = r_duty - w_step;
                            w_state_nxt = DOWN;
                        end
                    end else begin
                        w_state_nxt = w_up ? UP : DOWN;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_duty  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign duty_out = r_duty;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed bench for pwm_fade_controller with a 4-cycle base tick.
module tb_pwm_fade_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] target_duty = 8'h00;
    logic       fade_en = 1'b0;
    logic [3:0] step_size = 4'd1;
    logic [7:0] step_div = 8'd1;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    pwm_fade_controller #(
        .TICK_DIV (4),
        .TICK_W   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .target_duty (target_duty),
        .fade_en     (fade_en),
        .step_size   (step_size),
        .step_div    (step_div),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input logic [7:0] v);
        fade_en     = 1'b0;
        target_duty = v;
        cyc(1);
        checks++;
        if (duty_out !== v) begin
            errors++;
            $display("FAIL set_duty: duty_out=%h expected %h", duty_out, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; target_duty = 8'hFF; fade_en = 1'b1; step_size = 4'd1; step_div = 8'd1;
        cyc(3);
        checks++;
        if (duty_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: duty=%h busy=%b done=%b expected 00 0 0", duty_out, busy, done);
        end
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: busy=%b expected 0", busy);
        end
        cyc(1);
        checks++;
        if (busy !== 1'b1 || duty_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_enter_up: busy=%b duty=%h expected 1 00", busy, duty_out);
        end
        cyc(3);
        checks++;
        if (duty_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_pre_step: duty=%h expected 00", duty_out);
        end
        cyc(1);
        checks++;
        if (duty_out !== 8'h01) begin
            errors++;
            $display("FAIL reset_first_step: duty=%h expected 01", duty_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (duty_out !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mid_ramp: duty=%h busy=%b expected 00 0", duty_out, busy);
        end
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        set_duty(8'h00);
        step_size = 4'd8; step_div = 8'd2; target_duty = 8'h20; fade_en = 1'b1;
        cyc(1);
        checks++;
        if (busy !== 1'b1 || duty_out !== 8'h00) begin
            errors++;
            $display("FAIL ramp_enter: busy=%b duty=%h expected 1 00", busy, duty_out);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(7);
            checks++;
            if (duty_out !== 8'(8 * (k - 1))) begin
                errors++;
                $display("FAIL ramp_hold%0d: duty=%h expected %h", k, duty_out, 8'(8 * (k - 1)));
            end
            cyc(1);
            checks++;
            if (duty_out !== 8'(8 * k)) begin
                errors++;
                $display("FAIL ramp_step%0d: duty=%h expected %h", k, duty_out, 8'(8 * k));
            end
            checks++;
            if (k < 4 && (done !== 1'b0 || busy !== 1'b1)) begin
                errors++;
                $display("FAIL ramp_mid_status%0d: done=%b busy=%b expected 0 1", k, done, busy);
            end else if (k == 4 && (done !== 1'b1 || busy !== 1'b0)) begin
                errors++;
                $display("FAIL ramp_done: done=%b busy=%b expected 1 0", done, busy);
            end
        end
        cyc(1);
        checks++;
        if (done !== 1'b0 || duty_out !== 8'h20) begin
            errors++;
            $display("FAIL ramp_done_width: done=%b duty=%h expected 0 20", done, duty_out);
        end
    endtask

    task automatic test_snap();
        set_duty(8'h10);
        step_size = 4'd8; step_div = 8'd1; target_duty = 8'h13; fade_en = 1'b1;
        cyc(4);
        checks++;
        if (duty_out !== 8'h10) begin
            errors++;
            $display("FAIL snap_up_hold: duty=%h expected 10", duty_out);
        end
        cyc(1);
        checks++;
        if (duty_out !== 8'h13 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL snap_up: duty=%h done=%b busy=%b expected 13 1 0", duty_out, done, busy);
        end
        set_duty(8'h05);
        target_duty = 8'h00; fade_en = 1'b1;
        cyc(4);
        checks++;
        if (duty_out !== 8'h05 || busy !== 1'b1) begin
            errors++;
            $display("FAIL snap_down_hold: duty=%h busy=%b expected 05 1", duty_out, busy);
        end
        cyc(1);
        checks++;
        if (duty_out !== 8'h00 || done !== 1'b1) begin
            errors++;
            $display("FAIL snap_down: duty=%h done=%b expected 00 1", duty_out, done);
        end
    endtask

    task automatic test_retarget();
        set_duty(8'h10);
        step_size = 4'd8; step_div = 8'd1; target_duty = 8'h40; fade_en = 1'b1;
        cyc(5);
        checks++;
        if (duty_out !== 8'h18) begin
            errors++;
            $display("FAIL retarget_start: duty=%h expected 18", duty_out);
        end
        cyc(1);
        target_duty = 8'h08;
        cyc(2);
        checks++;
        if (duty_out !== 8'h18 || busy !== 1'b1) begin
            errors++;
            $display("FAIL retarget_flip: duty=%h busy=%b expected 18 1", duty_out, busy);
        end
        cyc(1);
        checks++;
        if (duty_out !== 8'h10) begin
            errors++;
            $display("FAIL retarget_step1: duty=%h expected 10", duty_out);
        end
        cyc(3);
        checks++;
        if (duty_out !== 8'h10 || done !== 1'b0) begin
            errors++;
            $display("FAIL retarget_hold: duty=%h done=%b expected 10 0", duty_out, done);
        end
        cyc(1);
        checks++;
        if (duty_out !== 8'h08 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL retarget_done: duty=%h done=%b busy=%b expected 08 1 0", duty_out, done, busy);
        end
    endtask

    task automatic test_retarget_equal();
        set_duty(8'h10);
        step_size = 4'd8; step_div = 8'd1; target_duty = 8'h40; fade_en = 1'b1;
        cyc(5);
        target_duty = 8'h18;
        cyc(1);
        checks++;
        if (duty_out !== 8'h18 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL retarget_equal: duty=%h done=%b busy=%b expected 18 1 0", duty_out, done, busy);
        end
        cyc(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL retarget_equal_width: done=%b expected 0", done);
        end
    endtask

    task automatic test_bypass();
        set_duty(8'h00);
        step_size = 4'd1; step_div = 8'd1; target_duty = 8'h80; fade_en = 1'b1;
        cyc(3);
        fade_en = 1'b0; target_duty = 8'hA5;
        #1;
        checks++;
        if (duty_out !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bypass_latency: duty=%h busy=%b expected 00 1", duty_out, busy);
        end
        cyc(1);
        checks++;
        if (duty_out !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL bypass: duty=%h busy=%b done=%b expected a5 0 0", duty_out, busy, done);
        end
        cyc(1);
        checks++;
        if (duty_out !== 8'hA5 || done !== 1'b0) begin
            errors++;
            $display("FAIL bypass_no_done: duty=%h done=%b expected a5 0", duty_out, done);
        end
    endtask

    task automatic test_zero_controls();
        set_duty(8'h00);
        step_size = 4'd0; step_div = 8'd0; target_duty = 8'h03; fade_en = 1'b1;
        cyc(1);
        for (int k = 1; k <= 3; k++) begin
            cyc(3);
            checks++;
            if (duty_out !== 8'(k - 1)) begin
                errors++;
                $display("FAIL zero_hold%0d: duty=%h expected %h", k, duty_out, 8'(k - 1));
            end
            cyc(1);
            checks++;
            if (duty_out !== 8'(k)) begin
                errors++;
                $display("FAIL zero_step%0d: duty=%h expected %h", k, duty_out, 8'(k));
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b expected 1 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_snap();
        test_retarget();
        test_retarget_equal();
        test_bypass();
        test_zero_controls();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
